// File: rtl/uart_pkg.sv
// Shared definitions for the CRC-protected UART link (transmitter and receiver).
// Holds the FSM state encoding used by both ends, the default bit period, and
// the 4-bit check-code generator together with the receiver-side checker so
// both ends of the link use one definition of the code.
package uart_pkg;

  // Frame sequencing states; the receiver uses the same encoding.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_CRC   = 3'd3,
    ST_STOP  = 3'd4
  } uart_state_e;

  // Default number of clock cycles each serial bit is held on the line.
  localparam int CLKS_PER_BIT_DEF = 1042;

  // Check code over one data byte.
  function automatic logic [3:0] crc4_gen(input logic [7:0] d);
    logic [3:0] c;
    c[3] = d[6] ^ d[2];
    c[2] = d[5] ^ d[1];
    c[1] = d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[2];
    c[0] = d[7] ^ d[6] ^ d[3] ^ d[2] ^ d[0];
    return c;
  endfunction

  // Receiver-side checker: zero remainder means the frame arrived intact.
  function automatic logic [3:0] crc4_check(input logic [7:0] d, input logic [3:0] c);
    return crc4_gen(d) ^ c;
  endfunction

endpackage

// File: rtl/uart_transmitter.sv
// UART transmitter for the CRC-protected link.
// Frame: start bit, 8 data bits LSB first, 4 check bits LSB first, stop bit.
// Build option UART_TX_CRC_EN: when defined the check-code field is sent
// (14-bit frame); when undefined the CRC state and register are removed and a
// plain 8N1 10-bit frame is sent. Ports are identical in both builds.
// All outputs except tx_ready are registered copies of the FSM view, so the
// line lags the state register by one cycle: a handshake at edge k drops tx
// at edge k+1, and tx_done/tx_ready are both high in the first IDLE cycle.
import uart_pkg::*;

module uart_transmitter #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  uart_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
`ifdef UART_TX_CRC_EN
  logic [3:0]    crc_q, crc_d;
`endif
  logic          tx_q, tx_d;
  logic          busy_q;
  logic          done_q, done_d;
  logic          bit_end;
  logic [CW-1:0] cnt_next;

  assign bit_end  = (cnt_q == CNT_LAST);
  assign cnt_next = bit_end ? '0 : (cnt_q + CNT_ONE);

  assign tx_ready = (state_q == ST_IDLE);
  assign tx       = tx_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

  // Next-state, baud counting, shift control and the line value for this state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
`ifdef UART_TX_CRC_EN
    crc_d   = crc_q;
`endif
    done_d  = 1'b0;
    tx_d    = 1'b1;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (tx_valid) begin
          shift_d = tx_data;
`ifdef UART_TX_CRC_EN
          crc_d   = crc4_gen(tx_data);
`endif
          state_d = ST_START;
        end
      end
      ST_START: begin
        tx_d  = 1'b0;
        cnt_d = cnt_next;
        if (bit_end) begin
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_d  = shift_q[0];
        cnt_d = cnt_next;
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            idx_d = '0;
`ifdef UART_TX_CRC_EN
            state_d = ST_CRC;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_CRC_EN
      ST_CRC: begin
        tx_d  = crc_q[0];
        cnt_d = cnt_next;
        if (bit_end) begin
          crc_d = {1'b0, crc_q[3:1]};
          if (idx_q == 3'd3) begin
            idx_d   = '0;
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`endif
      ST_STOP: begin
        tx_d  = 1'b1;
        cnt_d = cnt_next;
        if (bit_end) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= (state_q != ST_IDLE);
      done_q  <= done_d;
    end
  end

  // Payload registers; contents only matter once a handshake has loaded them.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
`ifdef UART_TX_CRC_EN
    crc_q   <= crc_d;
`endif
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter (CLKS_PER_BIT = 4).
// Follows the UART_TX_CRC_EN build option: 14-bit frames when defined,
// 10-bit 8N1 frames otherwise. Expected frames come from a bit-list model of
// the frame format and a mask-based parity model of the check code.
module tb_uart_transmitter;

  localparam int CPB = 4;
`ifdef UART_TX_CRC_EN
  localparam int NB = 14;
`else
  localparam int NB = 10;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int total = 0;
  int bad   = 0;

  uart_transmitter #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Check code as parity over the bit masks of each equation.
  function automatic logic [3:0] ref_crc(input logic [7:0] d);
    logic [3:0] c;
    c[3] = ^(d & 8'h44);
    c[2] = ^(d & 8'h22);
    c[1] = ^(d & 8'hDC);
    c[0] = ^(d & 8'hCD);
    return c;
  endfunction

  // Expected line value for frame bit b.
  function automatic logic ref_bit(input logic [7:0] d, input int b);
    logic [3:0] c;
    c = ref_crc(d);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (b == NB - 1) return 1'b1;
    return c[b-9];
  endfunction

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", int'(tx_ready), 1);
  endtask

  // Called just after the handshake edge; returns at the tx_done cycle.
  task automatic run_frame(input string tag, input logic [7:0] d, output logic [3:0] crc_rx);
    logic [NB-1:0] cap;
    int first_done = -1;
    cap = '0;
    for (int j = 0; j <= NB * CPB; j++) begin
      @(negedge clk);
      if (j == 0) chk({tag, "_lead"}, int'(tx), 1);
      if (j == 1) chk({tag, "_start_edge"}, int'(tx), 0);
      if (j >= 1 && ((j - 1) % CPB) == CPB / 2) cap[(j - 1) / CPB] = tx;
      if (j == (NB * CPB) / 2) begin
        chk({tag, "_busy_mid"}, int'(tx_busy), 1);
        chk({tag, "_ready_mid"}, int'(tx_ready), 0);
      end
      if (tx_done && first_done < 0) first_done = j;
    end
    for (int b = 0; b < NB; b++)
      chk($sformatf("%s_bit%0d", tag, b), int'(cap[b]), int'(ref_bit(d, b)));
    chk({tag, "_done_cycle"}, first_done, NB * CPB);
    chk({tag, "_ready_at_done"}, int'(tx_ready), 1);
`ifdef UART_TX_CRC_EN
    crc_rx = cap[12:9];
    chk({tag, "_rx_remainder"}, int'(ref_crc(cap[8:1]) ^ crc_rx), 0);
`else
    crc_rx = 4'h0;
`endif
  endtask

  task automatic send(input string tag, input logic [7:0] d, output logic [3:0] crc_rx);
    wait_ready();
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    run_frame(tag, d, crc_rx);
  endtask

  task automatic idle_watch(input string tag, input int cycles);
    int odd = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) odd++;
    end
    chk(tag, odd, 0);
  endtask

  initial begin
    logic [3:0] c;
    logic [7:0] r;
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx", int'(tx), 1);
    chk("rst_ready", int'(tx_ready), 1);
    chk("rst_busy", int'(tx_busy), 0);
    chk("rst_done", int'(tx_done), 0);
    idle_watch("idle_quiet", 8);

    send("a5", 8'hA5, c);
`ifdef UART_TX_CRC_EN
    chk("a5_crc", int'(c), 13);
`endif
    send("x00", 8'h00, c);
`ifdef UART_TX_CRC_EN
    chk("x00_crc", int'(c), 0);
`endif
    send("x01", 8'h01, c);
`ifdef UART_TX_CRC_EN
    chk("x01_crc", int'(c), 1);
`endif
    send("xff", 8'hFF, c);
`ifdef UART_TX_CRC_EN
    chk("xff_crc", int'(c), 3);
`endif

    // Back-to-back with valid held; second byte presented during frame one.
    wait_ready();
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_data = 8'hC3;
    run_frame("b2b1", 8'h3C, c);
    @(posedge clk);
    #1;
    run_frame("b2b2", 8'hC3, c);
    tx_valid = 1'b0;
    idle_watch("b2b_no_queue", 4 * CPB);

    // Reset during data bit 3 abandons the frame.
    wait_ready();
    tx_data  = 8'($urandom);
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    for (int j = 0; j <= 17; j++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_tx", int'(tx), 1);
    chk("midrst_busy", int'(tx_busy), 0);
    chk("midrst_ready", int'(tx_ready), 1);
    chk("midrst_done", int'(tx_done), 0);
    idle_watch("midrst_quiet", NB * CPB + 4);
    send("x5a", 8'h5A, c);

    // Reset coincident with a handshake: nothing accepted.
    wait_ready();
    rst      = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h81;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    tx_valid = 1'b0;
    idle_watch("rst_wins", 3 * CPB);

    for (int i = 0; i < 5; i++) begin
      r = 8'($urandom);
      send($sformatf("rnd%0d", i), r, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
